// File: rtl/sine_pkg.sv
// Shared constants and state encoding for the sine sweep controller.
package sine_pkg;

    localparam int ANGLE_W      = 9;
    localparam int MAG_W        = 7;
    localparam int DATA_W       = MAG_W + 1;
    localparam int EVAL_ANGLE_W = 7;
    localparam int EVAL_TIMEOUT = 64;
    localparam int TMR_W        = 7;

    localparam logic [ANGLE_W-1:0] FULL_CIRCLE   = ANGLE_W'(360);
    localparam logic [ANGLE_W-1:0] HALF          = ANGLE_W'(180);
    localparam logic [ANGLE_W-1:0] QUARTER       = ANGLE_W'(90);
    localparam logic [ANGLE_W-1:0] THREE_QUARTER = ANGLE_W'(270);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLD,
        ST_REQ,
        ST_WAIT,
        ST_PRESENT
    } state_t;

endpackage

// File: rtl/sine_sweep_ctrl_if.sv
// Control, evaluator and sample-output signals of the sweep controller.
interface sine_sweep_ctrl_if;
    import sine_pkg::*;

    logic                    en;
    logic [ANGLE_W-1:0]      phase0;
    logic [ANGLE_W-1:0]      step;
    logic                    eval_start;
    logic [EVAL_ANGLE_W-1:0] eval_angle;
    logic                    eval_done;
    logic [MAG_W-1:0]        eval_data;
    logic [DATA_W-1:0]       data_out;
    logic [ANGLE_W-1:0]      angle_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    wrap;
    logic                    cfg_err;
    logic                    timeout_err;

    // Environment side: register/control block, evaluator and output stage.
    modport master (
        output en, phase0, step, eval_done, eval_data, out_ready,
        input  eval_start, eval_angle, data_out, angle_out, out_valid,
               wrap, cfg_err, timeout_err
    );

    // Controller side.
    modport slave (
        input  en, phase0, step, eval_done, eval_data, out_ready,
        output eval_start, eval_angle, data_out, angle_out, out_valid,
               wrap, cfg_err, timeout_err
    );

endinterface

// File: rtl/sine_quadrant_fold.sv
// Folds an angle in 0..359 into 0..90 plus a sign flag for the sine.
module sine_quadrant_fold
    import sine_pkg::*;
(
    input  logic [ANGLE_W-1:0]      angle,
    output logic [EVAL_ANGLE_W-1:0] folded,
    output logic                    neg
);

    // Quadrant select: mirror about 90/270, sine negative past 180.
    always_comb begin
        folded = '0;
        neg    = 1'b0;
        if (angle <= QUARTER) begin
            folded = EVAL_ANGLE_W'(angle);
        end else if (angle <= HALF) begin
            folded = EVAL_ANGLE_W'(HALF - angle);
        end else if (angle <= THREE_QUARTER) begin
            folded = EVAL_ANGLE_W'(angle - HALF);
            neg    = 1'b1;
        end else begin
            folded = EVAL_ANGLE_W'(FULL_CIRCLE - angle);
            neg    = 1'b1;
        end
    end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Phase sweep sequencer: fold, evaluate, sign and present one sample at a time.
//
// state   | meaning
// IDLE    | waiting for EN, checks configuration
// FOLD    | register folded angle and sign
// REQ     | one-cycle evaluator start
// WAIT    | waiting for evaluator result, timeout down-counter running
// PRESENT | sample valid, waiting for downstream accept
module sine_sweep_ctrl
    import sine_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    sine_sweep_ctrl_if.slave  bus
);

    state_t                  state_q, state_d;
    logic [ANGLE_W-1:0]      phase_q, phase_d;
    logic [ANGLE_W-1:0]      step_q, step_d;
    logic [EVAL_ANGLE_W-1:0] eval_angle_q, eval_angle_d;
    logic                    neg_q, neg_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [DATA_W-1:0]       data_out_q, data_out_d;
    logic [ANGLE_W-1:0]      angle_out_q, angle_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    wrap_q, wrap_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    timeout_err_q, timeout_err_d;

    logic [EVAL_ANGLE_W-1:0] fold_angle;
    logic                    fold_neg;
    logic [ANGLE_W:0]        sum;
    logic [DATA_W-1:0]       mag_ext;

    sine_quadrant_fold u_fold (
        .angle  (phase_q),
        .folded (fold_angle),
        .neg    (fold_neg)
    );

    assign sum     = {1'b0, phase_q} + {1'b0, step_q};
    assign mag_ext = DATA_W'(bus.eval_data);

    // Next-state and datapath updates for the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        step_d        = step_q;
        eval_angle_d  = eval_angle_q;
        neg_d         = neg_q;
        tmr_d         = tmr_q;
        data_out_d    = data_out_q;
        angle_out_d   = angle_out_q;
        out_valid_d   = out_valid_q;
        wrap_d        = 1'b0;
        cfg_err_d     = cfg_err_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.en) begin
                    cfg_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end else if (bus.phase0 >= FULL_CIRCLE || bus.step >= FULL_CIRCLE) begin
                    cfg_err_d = 1'b1;
                end else begin
                    phase_d = bus.phase0;
                    step_d  = bus.step;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                eval_angle_d = fold_angle;
                neg_d        = fold_neg;
                state_d      = ST_REQ;
            end
            ST_REQ: begin
                tmr_d   = TMR_W'(EVAL_TIMEOUT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.eval_done) begin
                    // Two's-complement negate of zero is zero, so no -0 case.
                    data_out_d  = neg_q ? -mag_ext : mag_ext;
                    angle_out_d = phase_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end else if (tmr_q == '0) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_PRESENT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (sum >= {1'b0, FULL_CIRCLE}) begin
                        phase_d = ANGLE_W'(sum - {1'b0, FULL_CIRCLE});
                        wrap_d  = 1'b1;
                    end else begin
                        phase_d = ANGLE_W'(sum);
                    end
                    state_d = bus.en ? ST_FOLD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            step_q        <= '0;
            eval_angle_q  <= '0;
            neg_q         <= 1'b0;
            tmr_q         <= '0;
            data_out_q    <= '0;
            angle_out_q   <= '0;
            out_valid_q   <= 1'b0;
            wrap_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            step_q        <= step_d;
            eval_angle_q  <= eval_angle_d;
            neg_q         <= neg_d;
            tmr_q         <= tmr_d;
            data_out_q    <= data_out_d;
            angle_out_q   <= angle_out_d;
            out_valid_q   <= out_valid_d;
            wrap_q        <= wrap_d;
            cfg_err_q     <= cfg_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.eval_start  = (state_q == ST_REQ);
    assign bus.eval_angle  = eval_angle_q;
    assign bus.data_out    = data_out_q;
    assign bus.angle_out   = angle_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.wrap        = wrap_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Self-checking bench for sine_sweep_ctrl: evaluator model, output monitor,
// table-driven sweeps, randomized sweeps and hand-written corner sequences.
module tb_sine_sweep_ctrl;
    import sine_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sine_sweep_ctrl_if bus();

    sine_sweep_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int ev_lat = 4;
    bit ev_enable = 1'b1;
    bit ev_strict = 1'b1;
    int ev_cnt = 0;
    int ev_ang = 0;

    int got_angle[$];
    int got_data[$];
    int start_fold[$];
    int n_start = 0;
    int n_wrap = 0;
    int n_valid = 0;

    logic              pv = 1'b0;
    logic              pr = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    logic [ANGLE_W-1:0] pa = '0;

    typedef struct {
        int p0;
        int st;
        int n;
        int exp_angle;
        int exp_data;
        int exp_fold;
        int exp_wraps;
    } vec_t;

    vec_t tbl[11];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: fold is the 0..90 angle with the same |sin|, sign from sin itself.
    function automatic int ref_fold(int a);
        real s;
        s = $sin(real'(a) * PI / 180.0);
        if (s < 0.0) s = -s;
        if (s > 1.0) s = 1.0;
        return $rtoi($asin(s) * 180.0 / PI + 0.5);
    endfunction

    function automatic bit ref_neg(int a);
        return $sin(real'(a) * PI / 180.0) < -1.0e-9;
    endfunction

    function automatic int mag(int f);
        return $rtoi(127.0 * $sin(real'(f) * PI / 180.0) + 0.5001);
    endfunction

    function automatic int ref_data(int a);
        int m;
        m = mag(ref_fold(a));
        return ref_neg(a) ? -m : m;
    endfunction

    // Evaluator model: answers each start after ev_lat cycles with a single-cycle done.
    initial begin
        bus.eval_done = 1'b0;
        bus.eval_data = '0;
        forever begin
            @(negedge clk);
            bus.eval_done = 1'b0;
            if (ev_cnt > 0) begin
                ev_cnt--;
                if (ev_cnt == 0) begin
                    bus.eval_done = 1'b1;
                    bus.eval_data = MAG_W'(mag(ev_ang));
                    if (ev_strict) check("eval_angle_hold", int'(bus.eval_angle), ev_ang);
                end
            end
            if (bus.eval_start && ev_enable) begin
                ev_cnt = ev_lat;
                ev_ang = int'(bus.eval_angle);
            end
        end
    end

    // Output monitor: records accepted samples, start pulses, wraps; checks hold under backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) begin
                    check("hold_valid", int'(bus.out_valid), 1);
                    check("hold_data", int'(bus.data_out), int'(pd));
                    check("hold_angle", int'(bus.angle_out), int'(pa));
                end
                if (bus.out_valid) n_valid++;
                if (bus.out_valid && bus.out_ready) begin
                    got_angle.push_back(int'(bus.angle_out));
                    got_data.push_back(int'($signed(bus.data_out)));
                end
                if (bus.eval_start) begin
                    n_start++;
                    start_fold.push_back(int'(bus.eval_angle));
                    check("start_while_valid", int'(bus.out_valid), 0);
                end
                if (bus.wrap) n_wrap++;
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.data_out;
            pa = bus.angle_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_sweep(int p0, int st, int n, int lat, bit rnd_ready);
        int budget;
        got_angle.delete();
        got_data.delete();
        start_fold.delete();
        n_start = 0;
        n_wrap  = 0;
        ev_lat  = lat;
        @(posedge clk); #1;
        bus.phase0    = ANGLE_W'(p0);
        bus.step      = ANGLE_W'(st);
        bus.en        = 1'b1;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        budget = n * (lat + 20) * 4 + 50;
        while (got_angle.size() < n && budget > 0) begin
            @(posedge clk); #1;
            bus.en        = (got_angle.size() < n - 1);
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            budget--;
        end
        check("sweep_sample_count", got_angle.size(), n);
        bus.en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int p, wraps, k, p0, st, n, lat;

        tbl[0]  = '{0,   90,  1, 0,   0,    0,  0};
        tbl[1]  = '{0,   90,  2, 90,  127,  90, 0};
        tbl[2]  = '{0,   90,  3, 180, 0,    0,  0};
        tbl[3]  = '{0,   90,  4, 270, -127, 90, 1};
        tbl[4]  = '{0,   90,  5, 0,   0,    0,  1};
        tbl[5]  = '{150, 0,   1, 150, 64,   30, 0};
        tbl[6]  = '{210, 0,   2, 210, -64,  30, 0};
        tbl[7]  = '{330, 0,   1, 330, -64,  30, 0};
        tbl[8]  = '{100, 45,  3, 190, -22,  10, 0};
        tbl[9]  = '{300, 120, 2, 60,  110,  60, 1};
        tbl[10] = '{359, 1,   2, 0,   0,    0,  1};

        bus.en        = 1'b1;
        bus.phase0    = '0;
        bus.step      = ANGLE_W'(90);
        bus.out_ready = 1'b1;

        // Reset held with EN=1: everything must stay quiet.
        repeat (2) begin
            @(negedge clk);
            check("rst_eval_start", int'(bus.eval_start), 0);
        end
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_angle_out", int'(bus.angle_out), 0);
        check("rst_eval_angle", int'(bus.eval_angle), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        check("rst_timeout_err", int'(bus.timeout_err), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        @(posedge clk); #1;
        bus.en = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven sweeps: last accepted sample, its folded angle, wraps.
        for (int i = 0; i < 11; i++) begin
            run_sweep(tbl[i].p0, tbl[i].st, tbl[i].n, 4, 1'b0);
            n = tbl[i].n;
            check($sformatf("tbl%0d_angle", i), (got_angle.size() >= n) ? got_angle[n-1] : -1, tbl[i].exp_angle);
            check($sformatf("tbl%0d_data", i), (got_data.size() >= n) ? got_data[n-1] : -999, tbl[i].exp_data);
            check($sformatf("tbl%0d_fold", i), (start_fold.size() >= n) ? start_fold[n-1] : -1, tbl[i].exp_fold);
            check($sformatf("tbl%0d_wraps", i), n_wrap, tbl[i].exp_wraps);
            check($sformatf("tbl%0d_starts", i), n_start, n);
        end

        // Randomized sweeps against the arithmetic reference model.
        for (int r = 0; r < 8; r++) begin
            p0  = int'($urandom_range(0, 359));
            st  = int'($urandom_range(0, 359));
            n   = int'($urandom_range(1, 6));
            lat = int'($urandom_range(1, 8));
            run_sweep(p0, st, n, lat, 1'b1);
            p = p0;
            wraps = 0;
            for (int i = 0; i < n; i++) begin
                check($sformatf("rnd%0d_angle%0d", r, i), (got_angle.size() > i) ? got_angle[i] : -1, p);
                check($sformatf("rnd%0d_data%0d", r, i), (got_data.size() > i) ? got_data[i] : -999, ref_data(p));
                check($sformatf("rnd%0d_fold%0d", r, i), (start_fold.size() > i) ? start_fold[i] : -1, ref_fold(p));
                if (p + st >= 360) wraps++;
                p = (p + st) % 360;
            end
            check($sformatf("rnd%0d_wraps", r), n_wrap, wraps);
            check($sformatf("rnd%0d_starts", r), n_start, n);
        end

        // Backpressure: held sample, no new start; start two cycles after accept.
        got_angle.delete();
        got_data.delete();
        ev_lat = 3;
        @(posedge clk); #1;
        bus.phase0    = ANGLE_W'(45);
        bus.step      = ANGLE_W'(10);
        bus.en        = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_valid_seen", int'(bus.out_valid), 1);
        n_start = 0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_start", n_start, 0);
        check("bp_angle", int'(bus.angle_out), 45);
        check("bp_data", int'($signed(bus.data_out)), ref_data(45));
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_start_n0", int'(bus.eval_start), 0);
        @(negedge clk);
        check("bp_start_n1", int'(bus.eval_start), 0);
        @(negedge clk);
        check("bp_start_n2", int'(bus.eval_start), 1);
        bus.en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_drained", int'(bus.out_valid), 0);
        check("bp_count", got_angle.size(), 2);
        check("bp_second_angle", (got_angle.size() >= 2) ? got_angle[1] : -1, 55);

        // Configuration errors: out-of-range STEP or PHASE0.
        n_start = 0;
        @(posedge clk); #1;
        bus.phase0 = ANGLE_W'(10);
        bus.step   = ANGLE_W'(360);
        bus.en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("cfg_err_step", int'(bus.cfg_err), 1);
        check("cfg_no_start", n_start, 0);
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("cfg_err_clear", int'(bus.cfg_err), 0);
        @(posedge clk); #1;
        bus.phase0 = ANGLE_W'(360);
        bus.step   = ANGLE_W'(5);
        bus.en     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("cfg_err_phase", int'(bus.cfg_err), 1);
        check("cfg_no_start2", n_start, 0);
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Evaluator timeout: 64 WAIT cycles, then error and back to IDLE.
        ev_enable = 1'b0;
        n_valid   = 0;
        n_start   = 0;
        bus.phase0 = ANGLE_W'(20);
        bus.step   = ANGLE_W'(10);
        bus.en     = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.eval_start && k < 10);
        check("to_start_seen", int'(bus.eval_start), 1);
        repeat (64) @(negedge clk);
        check("to_not_yet", int'(bus.timeout_err), 0);
        @(negedge clk);
        check("to_err_set", int'(bus.timeout_err), 1);
        repeat (5) @(negedge clk);
        check("to_no_valid", n_valid, 0);
        check("to_one_start", n_start, 1);
        check("to_err_clear_idle", int'(bus.timeout_err), 0);
        ev_enable = 1'b1;

        // Reset during WAIT followed by a stray done.
        ev_lat    = 8;
        ev_strict = 1'b0;
        n_valid   = 0;
        n_start   = 0;
        @(posedge clk); #1;
        bus.phase0 = ANGLE_W'(90);
        bus.step   = ANGLE_W'(0);
        bus.en     = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.eval_start && k < 10);
        check("rw_start_seen", int'(bus.eval_start), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("rw_no_valid", n_valid, 0);
        check("rw_out_valid", int'(bus.out_valid), 0);
        check("rw_data_out", int'(bus.data_out), 0);
        check("rw_angle_out", int'(bus.angle_out), 0);
        check("rw_eval_angle", int'(bus.eval_angle), 0);
        check("rw_one_start", n_start, 1);
        ev_strict = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
